// File: rtl/fir_tap_sequencer.sv
// Address/control sequencer for the decimating FIR sample store: circular-buffer
// writes plus a newest-first tap walk with aligned coefficient and MAC strobes.
module fir_tap_sequencer #(
   parameter int unsigned NTAPS = 120,
   parameter int unsigned DECIM = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        x_strobe,
   input  logic [35:0] x_data,
   output logic        ram_wren,
   output logic [7:0]  ram_wraddress,
   output logic [35:0] ram_data,
   output logic [7:0]  ram_rdaddress,
   input  logic [35:0] ram_q,
   output logic [7:0]  coef_addr,
   output logic [35:0] mac_data,
   output logic        mac_en,
   output logic        mac_clr,
   output logic        mac_last,
   output logic        busy,
   output logic        overrun
);

   localparam int unsigned   AW      = 8;
   localparam int unsigned   FW      = AW + 1;
   localparam logic [AW-1:0] LAST_K  = AW'(NTAPS - 1);
   localparam logic [AW-1:0] LAST_PH = AW'(DECIM - 1);
   localparam logic [FW-1:0] FULL    = FW'(NTAPS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] wp;
   logic [AW-1:0] ph;
   logic [FW-1:0] fill;
   logic [FW-1:0] fill_inc;
   logic          trig;
   logic          start;
   logic [AW-1:0] k_nxt;
   logic [AW-1:0] rd_nxt;
   logic          en_nxt;
   logic          clr_nxt;
   logic          last_nxt;
   logic          busy_nxt;
   logic          ovr_nxt;

   assign fill_inc = fill + FW'(1);
   assign mac_data = ram_q;

   // Write side; trig marks a write cycle that may start a run (fill already satisfied)
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ram_wren      <= 1'b0;
         ram_wraddress <= '0;
         ram_data      <= '0;
         wp            <= '0;
         ph            <= '0;
         fill          <= '0;
         trig          <= 1'b0;
      end else begin
         ram_wren <= x_strobe;
         trig     <= x_strobe && (ph == LAST_PH) && (fill_inc >= FULL);
         if (x_strobe) begin
            ram_wraddress <= wp;
            ram_data      <= x_data;
            wp            <= wp + AW'(1);
            ph            <= (ph == LAST_PH) ? '0 : ph + AW'(1);
            if (fill < FULL) begin
               fill <= fill_inc;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (trig) state_nxt = S_RUN;
         S_RUN:   if (coef_addr == LAST_K) state_nxt = S_TAIL;
         S_TAIL:  state_nxt = trig ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // coef_addr doubles as the tap index k; read address walks down from base
   always_comb begin
      start    = trig && (state != S_RUN);
      k_nxt    = coef_addr;
      rd_nxt   = ram_rdaddress;
      en_nxt   = (state == S_RUN);
      clr_nxt  = (state == S_RUN) && (coef_addr == '0);
      last_nxt = (state == S_RUN) && (coef_addr == LAST_K);
      busy_nxt = (state_nxt != S_IDLE);
      ovr_nxt  = overrun || (trig && (state == S_RUN));
      if (start) begin
         k_nxt  = '0;
         rd_nxt = ram_wraddress;
      end else if ((state == S_RUN) && (coef_addr != LAST_K)) begin
         k_nxt  = coef_addr + AW'(1);
         rd_nxt = ram_rdaddress - AW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ram_rdaddress <= '0;
         coef_addr     <= '0;
         mac_en        <= 1'b0;
         mac_clr       <= 1'b0;
         mac_last      <= 1'b0;
         busy          <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         ram_rdaddress <= rd_nxt;
         coef_addr     <= k_nxt;
         mac_en        <= en_nxt;
         mac_clr       <= clr_nxt;
         mac_last      <= last_nxt;
         busy          <= busy_nxt;
         overrun       <= ovr_nxt;
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: three parameterisations, each with a RAM model and
// a run-schedule reference model built from sample counts and trigger times.
module tb_fir_tap_sequencer;

   localparam int NI = 3;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   logic        xs   [NI];
   logic [35:0] xd   [NI];
   logic        wren [NI];
   logic [7:0]  wa   [NI];
   logic [35:0] rdat [NI];
   logic [7:0]  rda  [NI];
   logic [35:0] q    [NI];
   logic [7:0]  ca   [NI];
   logic [35:0] md   [NI];
   logic        en   [NI];
   logic        clr  [NI];
   logic        last [NI];
   logic        bsy  [NI];
   logic        ovr  [NI];

   fir_tap_sequencer #(.NTAPS(4), .DECIM(2)) dut0 (
      .clock(clock), .reset_n(reset_n), .x_strobe(xs[0]), .x_data(xd[0]),
      .ram_wren(wren[0]), .ram_wraddress(wa[0]), .ram_data(rdat[0]), .ram_rdaddress(rda[0]),
      .ram_q(q[0]), .coef_addr(ca[0]), .mac_data(md[0]), .mac_en(en[0]), .mac_clr(clr[0]),
      .mac_last(last[0]), .busy(bsy[0]), .overrun(ovr[0]));

   fir_tap_sequencer #(.NTAPS(4), .DECIM(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .x_strobe(xs[1]), .x_data(xd[1]),
      .ram_wren(wren[1]), .ram_wraddress(wa[1]), .ram_data(rdat[1]), .ram_rdaddress(rda[1]),
      .ram_q(q[1]), .coef_addr(ca[1]), .mac_data(md[1]), .mac_en(en[1]), .mac_clr(clr[1]),
      .mac_last(last[1]), .busy(bsy[1]), .overrun(ovr[1]));

   fir_tap_sequencer dut2 (
      .clock(clock), .reset_n(reset_n), .x_strobe(xs[2]), .x_data(xd[2]),
      .ram_wren(wren[2]), .ram_wraddress(wa[2]), .ram_data(rdat[2]), .ram_rdaddress(rda[2]),
      .ram_q(q[2]), .coef_addr(ca[2]), .mac_data(md[2]), .mac_en(en[2]), .mac_clr(clr[2]),
      .mac_last(last[2]), .busy(bsy[2]), .overrun(ovr[2]));

   // 256 x 36 sample RAMs with 1-cycle registered read
   logic [35:0] mem [NI][256];
   always @(posedge clock) begin
      for (int i = 0; i < NI; i++) begin
         if (wren[i]) mem[i][wa[i]] <= rdat[i];
         q[i] <= mem[i][rda[i]];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state
   int          wcnt    [NI];
   int          free_at [NI];
   int          ovr_cyc [NI];
   logic [35:0] hist    [NI][256];
   bit          r_busy  [NI][256];
   bit          r_en    [NI][256];
   bit          r_clr   [NI][256];
   bit          r_last  [NI][256];
   bit          r_rdv   [NI][256];
   logic [7:0]  r_rd    [NI][256];
   logic [7:0]  r_coef  [NI][256];
   logic [35:0] r_dat   [NI][256];

   bit          e_wren [NI];
   bit          e_busy [NI];
   bit          e_en   [NI];
   bit          e_clr  [NI];
   bit          e_last [NI];
   bit          e_rdv  [NI];
   bit          e_ovr  [NI];
   logic [7:0]  e_wa   [NI];
   logic [7:0]  e_rd   [NI];
   logic [7:0]  e_coef [NI];
   logic [35:0] e_wd   [NI];
   logic [35:0] e_dat  [NI];

   function automatic int nt_of(int i);
      return (i == 2) ? 120 : 4;
   endfunction

   function automatic int dc_of(int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 8);
   endfunction

   function automatic logic [35:0] rnd36();
      return {4'($urandom()), $urandom()};
   endfunction

   task automatic model_reset(int i);
      for (int s = 0; s < 256; s++) begin
         r_busy[i][s] = 1'b0; r_en[i][s] = 1'b0; r_clr[i][s] = 1'b0;
         r_last[i][s] = 1'b0; r_rdv[i][s] = 1'b0;
      end
      wcnt[i] = 0; free_at[i] = 0; ovr_cyc[i] = 32'h7fff_ffff;
      e_wren[i] = 1'b0; e_busy[i] = 1'b0; e_en[i] = 1'b0; e_clr[i] = 1'b0;
      e_last[i] = 1'b0; e_rdv[i] = 1'b0; e_ovr[i] = 1'b0;
   endtask

   // One write (if any) in the current cycle; a valid trigger schedules a whole run ahead
   task automatic model_cycle(int i, logic s, logic [35:0] d);
      int sl, n, r, nt;
      sl = cyc & 255;
      nt = nt_of(i);
      e_busy[i] = r_busy[i][sl]; e_en[i] = r_en[i][sl]; e_clr[i] = r_clr[i][sl];
      e_last[i] = r_last[i][sl]; e_rdv[i] = r_rdv[i][sl]; e_rd[i] = r_rd[i][sl];
      e_coef[i] = r_coef[i][sl]; e_dat[i] = r_dat[i][sl];
      r_busy[i][sl] = 1'b0; r_en[i][sl] = 1'b0; r_clr[i][sl] = 1'b0;
      r_last[i][sl] = 1'b0; r_rdv[i][sl] = 1'b0;
      e_ovr[i]  = (cyc >= ovr_cyc[i]);
      e_wren[i] = s;
      if (s) begin
         n = wcnt[i];
         e_wa[i] = 8'(n);
         e_wd[i] = d;
         hist[i][n & 255] = d;
         wcnt[i] = n + 1;
         if ((wcnt[i] % dc_of(i)) == 0 && wcnt[i] >= nt) begin
            if (cyc + 1 >= free_at[i]) begin
               for (int j = 0; j < nt; j++) begin
                  r = cyc + 1 + j;
                  r_busy[i][r & 255] = 1'b1;
                  r_rdv[i][r & 255]  = 1'b1;
                  r_rd[i][r & 255]   = 8'(n - j);
                  r_coef[i][r & 255] = 8'(j);
                  r_busy[i][(r + 1) & 255] = 1'b1;
                  r_en[i][(r + 1) & 255]   = 1'b1;
                  r_clr[i][(r + 1) & 255]  = (j == 0);
                  r_last[i][(r + 1) & 255] = (j == nt - 1);
                  r_dat[i][(r + 1) & 255]  = hist[i][(n - j) & 255];
               end
               free_at[i] = cyc + nt + 2;
            end else if (ovr_cyc[i] > cyc + 1) begin
               ovr_cyc[i] = cyc + 1;
            end
         end
      end
   endtask

   task automatic tick();
      logic        s [NI];
      logic [35:0] d [NI];
      bit          rst_edge;
      for (int i = 0; i < NI; i++) begin
         s[i] = xs[i];
         d[i] = xd[i];
      end
      @(posedge clock);
      rst_edge = !reset_n;
      #1;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (rst_edge || !reset_n) model_reset(i);
         else model_cycle(i, s[i], d[i]);
         xs[i] = 1'b0;
      end
   endtask

   task automatic put(int i, logic [35:0] d);
      xs[i] = 1'b1;
      xd[i] = d;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if ({wren[i], wa[i], rdat[i], rda[i], ca[i], en[i], clr[i], last[i], bsy[i], ovr[i]} !== '0) begin
            n_fail++;
            $display("FAIL reset_state inst=%0d wren=%b wa=%0h rda=%0h coef=%0h en=%b busy=%b ovr=%b, all required 0",
                     i, wren[i], wa[i], rda[i], ca[i], en[i], bsy[i], ovr[i]);
         end
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_fill_sweep();
      int first_en_sample = -1;
      int nclr = 0;
      apply_reset();
      for (int s = 1; s <= 8; s++) begin
         put(0, 36'(s));
         for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if ({en[0], clr[0], last[0], bsy[0], wren[0]} !== {e_en[0], e_clr[0], e_last[0], e_busy[0], e_wren[0]}) begin
               n_fail++;
               $display("FAIL fill_strobes cyc=%0d got en/clr/last/busy/wren=%b%b%b%b%b exp=%b%b%b%b%b", cyc,
                        en[0], clr[0], last[0], bsy[0], wren[0], e_en[0], e_clr[0], e_last[0], e_busy[0], e_wren[0]);
            end
            if (e_rdv[0]) begin
               n_checks++;
               if ({rda[0], ca[0]} !== {e_rd[0], e_coef[0]}) begin
                  n_fail++;
                  $display("FAIL fill_rdaddr cyc=%0d got rd=%0d coef=%0d exp rd=%0d coef=%0d",
                           cyc, rda[0], ca[0], e_rd[0], e_coef[0]);
               end
            end
            if (e_en[0]) begin
               n_checks++;
               if (md[0] !== e_dat[0]) begin
                  n_fail++;
                  $display("FAIL fill_mac_data cyc=%0d got=%0h exp=%0h", cyc, md[0], e_dat[0]);
               end
            end
            if (e_wren[0]) begin
               n_checks++;
               if ({wa[0], rdat[0]} !== {e_wa[0], e_wd[0]}) begin
                  n_fail++;
                  $display("FAIL fill_write cyc=%0d got addr=%0d data=%0h exp addr=%0d data=%0h",
                           cyc, wa[0], rdat[0], e_wa[0], e_wd[0]);
               end
            end
            if (en[0] === 1'b1 && first_en_sample < 0) first_en_sample = s;
            if (clr[0] === 1'b1) nclr++;
         end
      end
      n_checks++;
      if (first_en_sample != 4) begin
         n_fail++;
         $display("FAIL fill_first_run got sample=%0d exp=4", first_en_sample);
      end
      n_checks++;
      if (nclr != 3) begin
         n_fail++;
         $display("FAIL fill_run_count got=%0d exp=3", nclr);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_rd [4] = '{8'd1, 8'd0, 8'd255, 8'd254};
      logic [7:0] got_rd [$];
      logic [7:0] prev_wa = 8'd0;
      bit         wrap_seen = 1'b0;
      apply_reset();
      for (int s = 1; s <= 266; s++) begin
         if (s <= 258) put(0, rnd36());
         for (int c = 0; c < 3; c++) begin
            tick();
            if (e_rdv[0]) begin
               if (e_coef[0] == 8'd0) got_rd.delete();
               got_rd.push_back(rda[0]);
               n_checks++;
               if ({rda[0], ca[0]} !== {e_rd[0], e_coef[0]}) begin
                  n_fail++;
                  $display("FAIL wrap_rdaddr cyc=%0d got rd=%0d coef=%0d exp rd=%0d coef=%0d",
                           cyc, rda[0], ca[0], e_rd[0], e_coef[0]);
               end
            end
            if (e_en[0]) begin
               n_checks++;
               if (md[0] !== e_dat[0]) begin
                  n_fail++;
                  $display("FAIL wrap_mac_data cyc=%0d got=%0h exp=%0h", cyc, md[0], e_dat[0]);
               end
            end
            n_checks++;
            if ({wren[0], en[0], ovr[0]} !== {e_wren[0], e_en[0], e_ovr[0]}) begin
               n_fail++;
               $display("FAIL wrap_ctrl cyc=%0d got wren/en/ovr=%b%b%b exp=%b%b%b",
                        cyc, wren[0], en[0], ovr[0], e_wren[0], e_en[0], e_ovr[0]);
            end
            if (e_wren[0]) begin
               n_checks++;
               if ({wa[0], rdat[0]} !== {e_wa[0], e_wd[0]}) begin
                  n_fail++;
                  $display("FAIL wrap_write cyc=%0d got addr=%0d exp addr=%0d", cyc, wa[0], e_wa[0]);
               end
               if (prev_wa == 8'd255 && wa[0] == 8'd0) wrap_seen = 1'b1;
               prev_wa = wa[0];
            end
         end
      end
      n_checks++;
      if (!wrap_seen) begin
         n_fail++;
         $display("FAIL wrap_wraddress got no 255->0 step, exp one");
      end
      n_checks++;
      if (got_rd.size() != 4) begin
         n_fail++;
         $display("FAIL wrap_last_run_len got=%0d exp=4", got_rd.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (got_rd[j] !== exp_rd[j]) begin
               n_fail++;
               $display("FAIL wrap_last_run tap=%0d got=%0d exp=%0d", j, got_rd[j], exp_rd[j]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int phase = 0;
      int n_en = 0;
      int n_clr = 0;
      int n_last = 0;
      apply_reset();
      for (int c = 0; c < 430; c++) begin
         if (c < 300) put(2, rnd36());
         tick();
         n_checks++;
         if ({en[2], clr[2], last[2], bsy[2], ovr[2], wren[2]} !==
             {e_en[2], e_clr[2], e_last[2], e_busy[2], e_ovr[2], e_wren[2]}) begin
            n_fail++;
            $display("FAIL b2b_ctrl cyc=%0d got en/clr/last/busy/ovr/wren=%b%b%b%b%b%b exp=%b%b%b%b%b%b", cyc,
                     en[2], clr[2], last[2], bsy[2], ovr[2], wren[2],
                     e_en[2], e_clr[2], e_last[2], e_busy[2], e_ovr[2], e_wren[2]);
         end
         if (e_wren[2]) begin
            n_checks++;
            if (wa[2] !== e_wa[2]) begin
               n_fail++;
               $display("FAIL b2b_wraddr cyc=%0d got=%0d exp=%0d", cyc, wa[2], e_wa[2]);
            end
         end
         if (e_en[2]) begin
            n_checks++;
            if (md[2] !== e_dat[2]) begin
               n_fail++;
               $display("FAIL b2b_mac_data cyc=%0d got=%0h exp=%0h", cyc, md[2], e_dat[2]);
            end
         end
         if (phase == 0 && clr[2] === 1'b1) phase = 1;
         if (phase == 1) begin
            if (en[2] === 1'b1) n_en++;
            if (clr[2] === 1'b1) n_clr++;
            if (last[2] === 1'b1) begin
               n_last++;
               phase = 2;
            end
         end
      end
      n_checks++;
      if (n_en != 120 || n_clr != 1 || n_last != 1) begin
         n_fail++;
         $display("FAIL b2b_run1 got en=%0d clr=%0d last=%0d exp en=120 clr=1 last=1", n_en, n_clr, n_last);
      end
      n_checks++;
      if (ovr[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_overrun got=%b exp=1", ovr[2]);
      end
   endtask

   task automatic test_exact_rate();
      bit seen_busy = 1'b0;
      int gaps = 0;
      int nclr = 0;
      apply_reset();
      for (int s = 1; s <= 22; s++) begin
         if (s <= 20) put(1, rnd36());
         for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({en[1], clr[1], last[1], bsy[1], ovr[1]} !== {e_en[1], e_clr[1], e_last[1], e_busy[1], e_ovr[1]}) begin
               n_fail++;
               $display("FAIL exact_ctrl cyc=%0d got en/clr/last/busy/ovr=%b%b%b%b%b exp=%b%b%b%b%b", cyc,
                        en[1], clr[1], last[1], bsy[1], ovr[1], e_en[1], e_clr[1], e_last[1], e_busy[1], e_ovr[1]);
            end
            if (e_en[1]) begin
               n_checks++;
               if (md[1] !== e_dat[1]) begin
                  n_fail++;
                  $display("FAIL exact_mac_data cyc=%0d got=%0h exp=%0h", cyc, md[1], e_dat[1]);
               end
            end
            if (bsy[1] === 1'b1) seen_busy = 1'b1;
            if (s <= 20 && seen_busy && bsy[1] !== 1'b1) gaps++;
            if (clr[1] === 1'b1) nclr++;
         end
      end
      n_checks++;
      if (gaps != 0 || nclr != 17) begin
         n_fail++;
         $display("FAIL exact_chain got idle_gaps=%0d runs=%0d exp idle_gaps=0 runs=17", gaps, nclr);
      end
      n_checks++;
      if (ovr[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL exact_overrun got=%b exp=0", ovr[1]);
      end
   endtask

   task automatic test_reset_midrun();
      int n_en = 0;
      int n_clr = 0;
      apply_reset();
      for (int s = 1; s <= 120; s++) begin
         put(2, rnd36());
         tick();
         if (en[2] === 1'b1) n_en++;
         tick();
         if (en[2] === 1'b1) n_en++;
      end
      for (int c = 0; c < 200 && n_en < 50; c++) begin
         tick();
         n_checks++;
         if ({en[2], bsy[2]} !== {e_en[2], e_busy[2]}) begin
            n_fail++;
            $display("FAIL midrun_pre cyc=%0d got en/busy=%b%b exp=%b%b", cyc, en[2], bsy[2], e_en[2], e_busy[2]);
         end
         if (en[2] === 1'b1) n_en++;
      end
      n_checks++;
      if (n_en != 50) begin
         n_fail++;
         $display("FAIL midrun_reach_tap50 got taps=%0d exp=50", n_en);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({wren[2], wa[2], rdat[2], rda[2], ca[2], en[2], clr[2], last[2], bsy[2], ovr[2]} !== '0) begin
         n_fail++;
         $display("FAIL midrun_async_reset wa=%0h rda=%0h coef=%0h en=%b busy=%b, all required 0",
                  wa[2], rda[2], ca[2], en[2], bsy[2]);
      end
      tick();
      tick();
      reset_n = 1'b1;
      n_en = 0;
      for (int s = 1; s <= 121; s++) begin
         put(2, rnd36());
         for (int c = 0; c < ((s == 121) ? 8 : 2); c++) begin
            tick();
            n_checks++;
            if ({en[2], clr[2], bsy[2]} !== {e_en[2], e_clr[2], e_busy[2]}) begin
               n_fail++;
               $display("FAIL midrun_post cyc=%0d got en/clr/busy=%b%b%b exp=%b%b%b",
                        cyc, en[2], clr[2], bsy[2], e_en[2], e_clr[2], e_busy[2]);
            end
            if (s < 120 && en[2] === 1'b1) n_en++;
            if (clr[2] === 1'b1) n_clr++;
         end
      end
      n_checks++;
      if (n_en != 0 || n_clr != 1) begin
         n_fail++;
         $display("FAIL midrun_refill got early_en=%0d runs=%0d exp early_en=0 runs=1", n_en, n_clr);
      end
   endtask

   task automatic test_latency();
      int t;
      int t_wren = -1;
      int t_rise = -1;
      int t_fall = -1;
      int t_clr  = -1;
      int t_last = -1;
      apply_reset();
      for (int s = 1; s <= 119; s++) begin
         put(2, rnd36());
         tick();
         tick();
      end
      for (int c = 0; c < 4; c++) tick();
      t = cyc;
      put(2, rnd36());
      for (int c = 0; c < 130; c++) begin
         tick();
         n_checks++;
         if ({en[2], bsy[2]} !== {e_en[2], e_busy[2]}) begin
            n_fail++;
            $display("FAIL latency_ctrl cyc=%0d got en/busy=%b%b exp=%b%b", cyc, en[2], bsy[2], e_en[2], e_busy[2]);
         end
         if (wren[2] === 1'b1 && t_wren < 0) t_wren = cyc;
         if (bsy[2] === 1'b1) begin
            if (t_rise < 0) t_rise = cyc;
            t_fall = cyc;
         end
         if (clr[2] === 1'b1 && t_clr < 0) t_clr = cyc;
         if (last[2] === 1'b1 && t_last < 0) t_last = cyc;
      end
      n_checks++;
      if (t_wren - t != 1 || t_rise - t != 2) begin
         n_fail++;
         $display("FAIL latency_start got wren=t+%0d busy_rise=t+%0d exp t+1 t+2", t_wren - t, t_rise - t);
      end
      n_checks++;
      if (t_clr - t != 3 || t_last - t != 122) begin
         n_fail++;
         $display("FAIL latency_mac got clr=t+%0d last=t+%0d exp t+3 t+122", t_clr - t, t_last - t);
      end
      n_checks++;
      if (t_fall - t != 122) begin
         n_fail++;
         $display("FAIL latency_busy_end got last_busy=t+%0d exp t+122", t_fall - t);
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         xs[i] = 1'b0;
         xd[i] = '0;
         model_reset(i);
      end
      test_reset();
      test_fill_sweep();
      test_wrap();
      test_back_to_back();
      test_exact_rate();
      test_reset_midrun();
      test_latency();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
